// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the 11-bit Hamming SECDED codec.
// Codeword positions, syndrome masks and error classification.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;

  localparam logic [SYN_W-1:0] POS_P1  = 4'd1;
  localparam logic [SYN_W-1:0] POS_P2  = 4'd2;
  localparam logic [SYN_W-1:0] POS_D0  = 4'd3;
  localparam logic [SYN_W-1:0] POS_P3  = 4'd4;
  localparam logic [SYN_W-1:0] POS_D1  = 4'd5;
  localparam logic [SYN_W-1:0] POS_D2  = 4'd6;
  localparam logic [SYN_W-1:0] POS_D3  = 4'd7;
  localparam logic [SYN_W-1:0] POS_P4  = 4'd8;
  localparam logic [SYN_W-1:0] POS_D4  = 4'd9;
  localparam logic [SYN_W-1:0] POS_D5  = 4'd10;
  localparam logic [SYN_W-1:0] POS_D6  = 4'd11;
  localparam logic [SYN_W-1:0] POS_D7  = 4'd12;
  localparam logic [SYN_W-1:0] POS_D8  = 4'd13;
  localparam logic [SYN_W-1:0] POS_D9  = 4'd14;
  localparam logic [SYN_W-1:0] POS_D10 = 4'd15;

  // Data bits covered by each Hamming parity bit (bit i = d_i).
  localparam logic [DATA_W-1:0] SYN_MASK_S1 = 11'h55B;
  localparam logic [DATA_W-1:0] SYN_MASK_S2 = 11'h66D;
  localparam logic [DATA_W-1:0] SYN_MASK_S3 = 11'h78E;
  localparam logic [DATA_W-1:0] SYN_MASK_S4 = 11'h7F0;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_DOUBLE
  } err_kind_t;

  function automatic err_kind_t classify(input logic [SYN_W-1:0] syn, input logic g);
    err_kind_t kind;
    kind = ERR_NONE;
    if (g) begin
      kind = ERR_SINGLE;
    end else if (syn != '0) begin
      kind = ERR_DOUBLE;
    end
    return kind;
  endfunction

  // Parity-bit positions and syn=0 leave the data untouched.
  function automatic logic [DATA_W-1:0] correctionMask(input logic [SYN_W-1:0] syn);
    logic [DATA_W-1:0] mask;
    mask = '0;
    case (syn)
      POS_D0:  mask = 11'h001;
      POS_D1:  mask = 11'h002;
      POS_D2:  mask = 11'h004;
      POS_D3:  mask = 11'h008;
      POS_D4:  mask = 11'h010;
      POS_D5:  mask = 11'h020;
      POS_D6:  mask = 11'h040;
      POS_D7:  mask = 11'h080;
      POS_D8:  mask = 11'h100;
      POS_D9:  mask = 11'h200;
      POS_D10: mask = 11'h400;
      POS_P1, POS_P2, POS_P3, POS_P4: mask = '0;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity check for the 11-bit SECDED code.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic              p0,
  input  logic              p1,
  input  logic              p2,
  input  logic              p3,
  input  logic              p4,
  output logic [SYN_W-1:0]  syn,
  output logic              g
);

  assign syn[0] = p1 ^ (^(data_in & SYN_MASK_S1));
  assign syn[1] = p2 ^ (^(data_in & SYN_MASK_S2));
  assign syn[2] = p3 ^ (^(data_in & SYN_MASK_S3));
  assign syn[3] = p4 ^ (^(data_in & SYN_MASK_S4));

  assign g = (^data_in) ^ p0 ^ p1 ^ p2 ^ p3 ^ p4;

endmodule

// File: rtl/hamming_secded_decoder.sv
// SECDED decoder: syndrome stage, correction stage with valid/ready
// handshake, and saturating single/double error counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              p0,
  input  logic              p1,
  input  logic              p2,
  input  logic              p3,
  input  logic              p4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_single,
  output logic              err_double,
  output logic [SYN_W-1:0]  err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYN_W-1:0]  synComb;
  logic              gComb;
  logic              adv1;
  logic              adv2;
  logic              inFire;
  logic              outFire;
  err_kind_t         kind;
  logic [DATA_W-1:0] correctedData;

  logic              s1Valid_q, s1Valid_d;
  logic [DATA_W-1:0] s1Data_q, s1Data_d;
  logic [SYN_W-1:0]  s1Syn_q, s1Syn_d;
  logic              s1G_q, s1G_d;

  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] dataOut_q, dataOut_d;
  logic              errSingle_q, errSingle_d;
  logic              errDouble_q, errDouble_d;
  logic [SYN_W-1:0]  errPos_q, errPos_d;

  logic [CNT_W-1:0]  cntSingle_q, cntSingle_d;
  logic [CNT_W-1:0]  cntDouble_q, cntDouble_d;

  hamming_syndrome u_syndrome (
    .data_in (data_in),
    .p0      (p0),
    .p1      (p1),
    .p2      (p2),
    .p3      (p3),
    .p4      (p4),
    .syn     (synComb),
    .g       (gComb)
  );

  // Each stage advances when the stage after it is empty or draining.
  assign adv2    = !outValid_q | out_ready;
  assign adv1    = !s1Valid_q | adv2;
  assign inFire  = in_valid & adv1;
  assign outFire = outValid_q & out_ready;

  assign kind          = classify(s1Syn_q, s1G_q);
  assign correctedData = (kind == ERR_SINGLE) ? (s1Data_q ^ correctionMask(s1Syn_q))
                                              : s1Data_q;

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s1Syn_d   = s1Syn_q;
    s1G_d     = s1G_q;
    if (adv1) begin
      s1Valid_d = in_valid;
    end
    if (inFire) begin
      s1Data_d = data_in;
      s1Syn_d  = synComb;
      s1G_d    = gComb;
    end
  end

  always_comb begin
    outValid_d  = outValid_q;
    dataOut_d   = dataOut_q;
    errSingle_d = errSingle_q;
    errDouble_d = errDouble_q;
    errPos_d    = errPos_q;
    if (adv2) begin
      outValid_d = s1Valid_q;
    end
    if (adv2 && s1Valid_q) begin
      dataOut_d   = correctedData;
      errSingle_d = (kind == ERR_SINGLE);
      errDouble_d = (kind == ERR_DOUBLE);
      errPos_d    = s1Syn_q;
    end
  end

  // Clear wins over a same-cycle increment; counts saturate at all-ones.
  always_comb begin
    cntSingle_d = cntSingle_q;
    cntDouble_d = cntDouble_q;
    if (cnt_clr) begin
      cntSingle_d = '0;
      cntDouble_d = '0;
    end else if (outFire) begin
      if (errSingle_q && (cntSingle_q != CNT_MAX)) begin
        cntSingle_d = cntSingle_q + CNT_ONE;
      end
      if (errDouble_q && (cntDouble_q != CNT_MAX)) begin
        cntDouble_d = cntDouble_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q   <= 1'b0;
      s1Data_q    <= '0;
      s1Syn_q     <= '0;
      s1G_q       <= 1'b0;
      outValid_q  <= 1'b0;
      dataOut_q   <= '0;
      errSingle_q <= 1'b0;
      errDouble_q <= 1'b0;
      errPos_q    <= '0;
      cntSingle_q <= '0;
      cntDouble_q <= '0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Data_q    <= s1Data_d;
      s1Syn_q     <= s1Syn_d;
      s1G_q       <= s1G_d;
      outValid_q  <= outValid_d;
      dataOut_q   <= dataOut_d;
      errSingle_q <= errSingle_d;
      errDouble_q <= errDouble_d;
      errPos_q    <= errPos_d;
      cntSingle_q <= cntSingle_d;
      cntDouble_q <= cntDouble_d;
    end
  end

  assign in_ready   = adv1;
  assign out_valid  = outValid_q;
  assign data_out   = dataOut_q;
  assign err_single = errSingle_q;
  assign err_double = errDouble_q;
  assign err_pos    = errPos_q;
  assign cnt_single = cntSingle_q;
  assign cnt_double = cntDouble_q;

endmodule
